// File: rtl/shift_pkg.sv
// shift_pkg: register map, shift modes, status bit positions and FSM states for shift_engine
package shift_pkg;
   localparam logic [1:0] REG_CTRL    = 2'b00;
   localparam logic [1:0] REG_OPERAND = 2'b01;
   localparam logic [1:0] REG_RESULT  = 2'b10;
   localparam logic [1:0] REG_STATUS  = 2'b11;
   localparam logic [1:0] MODE_LSL = 2'b00;
   localparam logic [1:0] MODE_ASR = 2'b01;
   localparam logic [1:0] MODE_ROT = 2'b10;
   localparam int ST_BUSY = 0;
   localparam int ST_DONE = 1;
   localparam int ST_ERR  = 2;
   typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/shift_step.sv
// shift_step: one-bit shift of a DATA_W word; mode 11 falls through to logical
module shift_step
   import shift_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic [DATA_W-1:0] d,
   input  logic              dir,
   input  logic [1:0]        mode,
   output logic [DATA_W-1:0] q
);
   logic fill_l, fill_r;
   always_comb begin
      fill_r = mode == MODE_ASR ? d[DATA_W-1] : mode == MODE_ROT ? d[0] : 1'b0;
      fill_l = mode == MODE_ROT ? d[DATA_W-1] : 1'b0;
      q = dir ? {fill_r, d[DATA_W-1:1]} : {d[DATA_W-2:0], fill_l};
   end
endmodule

// File: rtl/shift_engine.sv
// shift_engine: memory-mapped sequential shifter, one bit per clock, with status and done irq
module shift_engine
   import shift_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        reg_sel,
   input  logic [DATA_W-1:0] data_in,
   input  logic              cs,
   input  logic              we,
   output logic [DATA_W-1:0] data_out,
   output logic              irq
);
   localparam int SHAMT_W = $clog2(DATA_W);
   state_t state_q, state_d;
   logic [DATA_W-1:0] ctrl_q, ctrl_d, operand_q, operand_d, result_q, result_d, sh_q, sh_d;
   logic [DATA_W-1:0] step, status;
   logic [SHAMT_W-1:0] cnt_q, cnt_d, amt;
   logic busy_q, busy_d, done_q, done_d, err_q, err_d, irq_q, irq_d;
   logic wr_ctrl, wr_op, err_clr;
   assign amt     = ctrl_q[SHAMT_W-1:0];
   assign wr_ctrl = cs && we && reg_sel == REG_CTRL;
   assign wr_op   = cs && we && reg_sel == REG_OPERAND;
   assign err_clr = cs && we && reg_sel == REG_STATUS && data_in[ST_ERR];
   shift_step #(.DATA_W(DATA_W)) u_step (
      .d   (sh_q),
      .dir (ctrl_q[DATA_W-1]),
      .mode(ctrl_q[DATA_W-2:DATA_W-3]),
      .q   (step)
   );
   always_comb begin
      state_d   = state_q;
      ctrl_d    = ctrl_q;
      operand_d = operand_q;
      result_d  = result_q;
      sh_d      = sh_q;
      cnt_d     = cnt_q;
      busy_d    = busy_q;
      done_d    = done_q;
      irq_d     = 1'b0;
      err_d     = err_q & ~err_clr;
      if (state_q == IDLE) begin
         if (wr_ctrl) ctrl_d = data_in;
         if (wr_op) begin
            operand_d = data_in;
            sh_d      = data_in;
            done_d    = 1'b0;
            if (amt != '0) begin
               cnt_d   = amt;
               busy_d  = 1'b1;
               state_d = RUN;
            end else begin
               result_d = data_in;
               done_d   = 1'b1;
               irq_d    = 1'b1;
            end
         end
      end else begin
         // a new error wins over a simultaneous clear
         if (wr_ctrl || wr_op) err_d = 1'b1;
         sh_d  = step;
         cnt_d = cnt_q - 1'b1;
         if (cnt_q == SHAMT_W'(1)) begin
            result_d = step;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            irq_d    = 1'b1;
            state_d  = IDLE;
         end
      end
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         ctrl_q    <= '0;
         operand_q <= '0;
         result_q  <= '0;
         sh_q      <= '0;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         irq_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         ctrl_q    <= ctrl_d;
         operand_q <= operand_d;
         result_q  <= result_d;
         sh_q      <= sh_d;
         cnt_q     <= cnt_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
         irq_q     <= irq_d;
      end
   end
   always_comb begin
      status          = '0;
      status[ST_BUSY] = busy_q;
      status[ST_DONE] = done_q;
      status[ST_ERR]  = err_q;
   end
   assign data_out = !cs ? '0 :
                     reg_sel == REG_CTRL    ? ctrl_q :
                     reg_sel == REG_OPERAND ? operand_q :
                     reg_sel == REG_RESULT  ? result_q : status;
   assign irq = irq_q;
endmodule

// File: tb/tb_shift_engine.sv
// tb_shift_engine: directed checks of shift_engine at DATA_W=16 and DATA_W=32
module tb_shift_engine;
   import shift_pkg::*;
   logic clk = 1'b0, reset = 1'b0;
   logic [1:0] sel16 = '0, sel32 = '0;
   logic [15:0] din16 = '0, dout16;
   logic [31:0] din32 = '0, dout32;
   logic cs16 = 1'b0, we16 = 1'b0, cs32 = 1'b0, we32 = 1'b0, irq16, irq32;
   int errors = 0, checks = 0, irqs16 = 0;

   shift_engine #(.DATA_W(16)) dut16 (
      .clk(clk), .reset(reset), .reg_sel(sel16), .data_in(din16),
      .cs(cs16), .we(we16), .data_out(dout16), .irq(irq16)
   );
   shift_engine #(.DATA_W(32)) dut32 (
      .clk(clk), .reset(reset), .reg_sel(sel32), .data_in(din32),
      .cs(cs32), .we(we32), .data_out(dout32), .irq(irq32)
   );

   always #5 clk = ~clk;
   always @(negedge clk) if (irq16) irqs16++;

   task automatic wr16(input logic [1:0] s, input logic [15:0] v);
      @(negedge clk);
      cs16 = 1'b1; we16 = 1'b1; sel16 = s; din16 = v;
      @(posedge clk);
      #1 cs16 = 1'b0; we16 = 1'b0;
   endtask

   task automatic rd16(input logic [1:0] s, output logic [15:0] v);
      cs16 = 1'b1; we16 = 1'b0; sel16 = s;
      #1 v = dout16;
      cs16 = 1'b0;
   endtask

   task automatic wait16(output int n);
      logic [15:0] s;
      n = 0;
      rd16(REG_STATUS, s);
      while (s[ST_BUSY] && n < 100) begin
         @(posedge clk);
         #1 n++;
         rd16(REG_STATUS, s);
      end
   endtask

   task automatic wr32(input logic [1:0] s, input logic [31:0] v);
      @(negedge clk);
      cs32 = 1'b1; we32 = 1'b1; sel32 = s; din32 = v;
      @(posedge clk);
      #1 cs32 = 1'b0; we32 = 1'b0;
   endtask

   task automatic rd32(input logic [1:0] s, output logic [31:0] v);
      cs32 = 1'b1; we32 = 1'b0; sel32 = s;
      #1 v = dout32;
      cs32 = 1'b0;
   endtask

   task automatic test_reset;
      logic [15:0] v;
      logic [31:0] w;
      for (int r = 0; r < 4; r++) begin
         rd16(2'(r), v);
         checks++;
         if (v !== 16'h0) begin errors++; $display("FAIL reset reg%0d: got %h want 0000", r, v); end
      end
      rd32(REG_RESULT, w);
      checks++;
      if (w !== 32'h0) begin errors++; $display("FAIL reset32 result: got %h want 0", w); end
      checks++;
      if (irq16 !== 1'b0) begin errors++; $display("FAIL reset irq: got %b want 0", irq16); end
   endtask

   task automatic test_lsr;
      logic [15:0] v;
      int n, i0;
      i0 = irqs16;
      wr16(REG_CTRL, 16'h8002);
      wr16(REG_OPERAND, 16'h0008);
      wait16(n);
      checks++;
      if (n != 2) begin errors++; $display("FAIL lsr2 busy cycles: got %0d want 2", n); end
      rd16(REG_RESULT, v);
      checks++;
      if (v !== 16'h0002) begin errors++; $display("FAIL lsr2 result: got %h want 0002", v); end
      rd16(REG_STATUS, v);
      checks++;
      if (v !== 16'h0002) begin errors++; $display("FAIL lsr2 status: got %h want 0002", v); end
      repeat (2) @(posedge clk);
      checks++;
      if (irqs16 - i0 != 1) begin errors++; $display("FAIL lsr2 irq pulses: got %0d want 1", irqs16 - i0); end
      #1 cs16 = 1'b0; sel16 = REG_RESULT;
      #1 checks++;
      if (dout16 !== 16'h0) begin errors++; $display("FAIL cs0 read: got %h want 0000", dout16); end
      wr16(REG_RESULT, 16'hBEEF);
      rd16(REG_RESULT, v);
      checks++;
      if (v !== 16'h0002) begin errors++; $display("FAIL result write ignored: got %h want 0002", v); end
   endtask

   task automatic test_asr;
      logic [15:0] v;
      int n;
      wr16(REG_CTRL, 16'hA004);
      wr16(REG_OPERAND, 16'h8000);
      wait16(n);
      rd16(REG_RESULT, v);
      checks++;
      if (n != 4 || v !== 16'hF800) begin errors++; $display("FAIL asr4 neg: got %h/%0d want f800/4", v, n); end
      wr16(REG_OPERAND, 16'h4000);
      wait16(n);
      rd16(REG_RESULT, v);
      checks++;
      if (v !== 16'h0400) begin errors++; $display("FAIL asr4 pos: got %h want 0400", v); end
      wr16(REG_CTRL, 16'h2003);
      wr16(REG_OPERAND, 16'h8001);
      wait16(n);
      rd16(REG_RESULT, v);
      checks++;
      if (v !== 16'h0008) begin errors++; $display("FAIL asl3: got %h want 0008", v); end
   endtask

   task automatic test_rotate;
      logic [15:0] v;
      int n;
      wr16(REG_CTRL, 16'h4001);
      wr16(REG_OPERAND, 16'h8001);
      wait16(n);
      rd16(REG_RESULT, v);
      checks++;
      if (v !== 16'h0003) begin errors++; $display("FAIL rol1: got %h want 0003", v); end
      wr16(REG_CTRL, 16'hC00F);
      wr16(REG_OPERAND, 16'h0001);
      rd16(REG_RESULT, v);
      checks++;
      if (v !== 16'h0003) begin errors++; $display("FAIL result held in run: got %h want 0003", v); end
      wait16(n);
      checks++;
      if (n != 15) begin errors++; $display("FAIL ror15 busy cycles: got %0d want 15", n); end
      rd16(REG_RESULT, v);
      checks++;
      if (v !== 16'h0002) begin errors++; $display("FAIL ror15: got %h want 0002", v); end
   endtask

   task automatic test_amount_zero;
      logic [15:0] v;
      wr16(REG_CTRL, 16'h0000);
      wr16(REG_OPERAND, 16'h1234);
      checks++;
      if (irq16 !== 1'b1) begin errors++; $display("FAIL amt0 irq: got %b want 1", irq16); end
      rd16(REG_STATUS, v);
      checks++;
      if (v !== 16'h0002) begin errors++; $display("FAIL amt0 status: got %h want 0002", v); end
      rd16(REG_RESULT, v);
      checks++;
      if (v !== 16'h1234) begin errors++; $display("FAIL amt0 result: got %h want 1234", v); end
      @(posedge clk);
      #1 checks++;
      if (irq16 !== 1'b0) begin errors++; $display("FAIL amt0 irq width: got %b want 0", irq16); end
   endtask

   task automatic test_busy_error;
      logic [15:0] v;
      int n;
      wr16(REG_CTRL, 16'h8008);
      wr16(REG_OPERAND, 16'h1200);
      wr16(REG_OPERAND, 16'hFFFF);
      wr16(REG_CTRL, 16'h0000);
      wait16(n);
      checks++;
      if (n != 6) begin errors++; $display("FAIL err remaining cycles: got %0d want 6", n); end
      rd16(REG_RESULT, v);
      checks++;
      if (v !== 16'h0012) begin errors++; $display("FAIL err result: got %h want 0012", v); end
      rd16(REG_STATUS, v);
      checks++;
      if (v !== 16'h0006) begin errors++; $display("FAIL err status: got %h want 0006", v); end
      rd16(REG_CTRL, v);
      checks++;
      if (v !== 16'h8008) begin errors++; $display("FAIL err ctrl kept: got %h want 8008", v); end
      rd16(REG_OPERAND, v);
      checks++;
      if (v !== 16'h1200) begin errors++; $display("FAIL err operand kept: got %h want 1200", v); end
      wr16(REG_STATUS, 16'h0004);
      rd16(REG_STATUS, v);
      checks++;
      if (v !== 16'h0002) begin errors++; $display("FAIL err clear: got %h want 0002", v); end
   endtask

   task automatic test_reset_mid_run;
      logic [15:0] v;
      wr16(REG_CTRL, 16'h8004);
      wr16(REG_OPERAND, 16'hFFFF);
      @(posedge clk);
      #2 reset = 1'b0;
      #1 for (int r = 0; r < 4; r++) begin
         rd16(2'(r), v);
         checks++;
         if (v !== 16'h0) begin errors++; $display("FAIL midrun reset reg%0d: got %h want 0000", r, v); end
      end
      checks++;
      if (irq16 !== 1'b0) begin errors++; $display("FAIL midrun reset irq: got %b want 0", irq16); end
      @(negedge clk) reset = 1'b1;
   endtask

   task automatic test_wide;
      logic [31:0] w;
      int n;
      wr32(REG_CTRL, 32'h0000_001F);
      wr32(REG_OPERAND, 32'h0000_0001);
      n = 0;
      rd32(REG_STATUS, w);
      while (w[ST_BUSY] && n < 100) begin
         @(posedge clk);
         #1 n++;
         rd32(REG_STATUS, w);
      end
      checks++;
      if (n != 31) begin errors++; $display("FAIL w32 busy cycles: got %0d want 31", n); end
      rd32(REG_RESULT, w);
      checks++;
      if (w !== 32'h8000_0000) begin errors++; $display("FAIL w32 result: got %h want 80000000", w); end
   endtask

   initial begin
      #12;
      test_reset;
      @(negedge clk) reset = 1'b1;
      test_lsr;
      test_asr;
      test_rotate;
      test_amount_zero;
      test_busy_error;
      test_reset_mid_run;
      test_wide;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
